fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_reorder_ram.sv | 24 ++
 rtl/fft_out_reorder.sv | 125 ++++++++++++
 tb/tb_fft_out_reorder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder block: frame-length encodings,
// read-side state type and the bit helpers used for address generation.
package fft_pkg;

    localparam logic [1:0] SEL_N16  = 2'b00;
    localparam logic [1:0] SEL_N64  = 2'b01;
    localparam logic [1:0] SEL_N32  = 2'b11;
    localparam logic [1:0] SEL_N128 = 2'b10;

    localparam int BR_W = 16;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    function automatic int log2c(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // The encoding is not monotonic in N: 11 selects 32 and 10 selects 128.
    function automatic logic [3:0] sel_to_nn(input logic [1:0] sel);
        logic [3:0] nn;
        case (sel)
            SEL_N16: nn = 4'd4;
            SEL_N64: nn = 4'd6;
            SEL_N32: nn = 4'd5;
            default: nn = 4'd7;
        endcase
        return nn;
    endfunction

    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] value,
                                               input logic [3:0]      nbits);
        logic [BR_W-1:0] r;
        logic [3:0]      src;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            src = 4'(int'(nbits) - 1 - i);
            if (i < int'(nbits)) r[i] = value[src];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank is the address MSB.
// One write port and one read port with a registered output.
module fft_reorder_ram
    import fft_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Converts bit-reversed FFT output frames into natural order using two ping-pong
// banks; writes scatter to bit-reversed addresses, reads sweep linearly.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MAX_N = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic [1:0]       sel,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [6:0]       do_idx,
    output logic             ovf,
    output rd_state_e        dbg_state
);

    localparam int AW = log2c(MAX_N);

    // Streaming handshake: di_en qualifies one sample per cycle and do_en one
    // output per cycle; there is no backpressure on either side.

    logic [AW-1:0]      r_wr_cnt;
    logic [3:0]         r_wr_nn;
    logic               r_wr_bank;
    logic               r_rd_bank;
    rd_state_e          r_state;
    logic [AW-1:0]      r_rd_cnt;
    logic [AW-1:0]      r_rd_last;
    logic               r_rd_valid;
    logic [AW-1:0]      r_rd_idx;

    logic [3:0]         w_nn;
    logic [AW-1:0]      w_wr_last;
    logic [AW-1:0]      w_wr_lo;
    logic               w_frame_done;
    logic               w_rd_final;
    logic               w_swap_ok;
    logic [2*WIDTH-1:0] w_rd_data;

    // N is taken from sel only on the first sample; later sel changes are ignored.
    assign w_nn         = (r_wr_cnt == '0) ? sel_to_nn(sel) : r_wr_nn;
    assign w_wr_last    = AW'((32'd1 << w_nn) - 32'd1);
    assign w_wr_lo      = AW'(bitrev(BR_W'(r_wr_cnt), w_nn));
    assign w_frame_done = di_en && (r_wr_cnt == w_wr_last);
    assign w_rd_final   = (r_state == RD_READ) && (r_rd_cnt == r_rd_last);
    assign w_swap_ok    = (r_state == RD_IDLE) || w_rd_final;
    assign dbg_state    = r_state;

    fft_reorder_ram #(
        .DW (2*WIDTH),
        .AW (AW+1)
    ) u_ram (
        .clock     (clock),
        .i_wr_en   (di_en && !reset),
        .i_wr_addr ({r_wr_bank, w_wr_lo}),
        .i_wr_data ({di_re, di_im}),
        .i_rd_addr ({r_rd_bank, r_rd_cnt}),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_cnt   <= '0;
            r_wr_nn    <= 4'd4;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b1;
            r_state    <= RD_IDLE;
            r_rd_cnt   <= '0;
            r_rd_last  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            do_en      <= 1'b0;
            do_re      <= '0;
            do_im      <= '0;
            do_idx     <= '0;
            ovf        <= 1'b0;
        end else begin
            ovf        <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;

            if (di_en) begin
                if (r_wr_cnt == '0) r_wr_nn <= w_nn;
                r_wr_cnt <= w_frame_done ? '0 : r_wr_cnt + 1'b1;
            end

            case (r_state)
                RD_IDLE: begin
                end
                RD_READ: begin
                    r_rd_valid <= 1'b1;
                    r_rd_idx   <= r_rd_cnt;
                    r_rd_cnt   <= r_rd_cnt + 1'b1;
                    if (w_rd_final) r_state <= RD_IDLE;
                end
                default: r_state <= RD_IDLE;
            endcase

            // A swap on the final read edge is safe: that read still uses the old bank.
            if (w_frame_done) begin
                if (w_swap_ok) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_rd_bank <= r_wr_bank;
                    r_state   <= RD_READ;
                    r_rd_cnt  <= '0;
                    r_rd_last <= w_wr_last;
                end else begin
                    ovf <= 1'b1;
                end
            end

            do_en  <= r_rd_valid;
            do_re  <= r_rd_valid ? w_rd_data[2*WIDTH-1:WIDTH] : '0;
            do_im  <= r_rd_valid ? w_rd_data[WIDTH-1:0] : '0;
            do_idx <= r_rd_valid ? 7'(r_rd_idx) : 7'd0;
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: frames of known data are driven and the
// captured natural-order bursts are compared against hand-derived expectations.
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic [1:0]   sel   = 2'b00;
    logic         do_en;
    logic [W-1:0] do_re;
    logic [W-1:0] do_im;
    logic [6:0]   do_idx;
    logic         ovf;
    rd_state_e    dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    logic [W-1:0] cap_re[$];
    logic [W-1:0] cap_im[$];
    logic [6:0]   cap_idx[$];
    int           cap_cyc[$];
    int           ovf_cnt = 0;
    int           ovf_cyc = -1;

    fft_out_reorder #(.WIDTH(W), .MAX_N(128)) dut (
        .clock     (clock),
        .reset     (reset),
        .di_en     (di_en),
        .di_re     (di_re),
        .di_im     (di_im),
        .sel       (sel),
        .do_en     (do_en),
        .do_re     (do_re),
        .do_im     (do_im),
        .do_idx    (do_idx),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor (opposite edge) ----------------
    always @(negedge clock) begin
        if (mon_on) begin
            if (do_en === 1'b1) begin
                cap_re.push_back(do_re);
                cap_im.push_back(do_im);
                cap_idx.push_back(do_idx);
                cap_cyc.push_back(cyc);
            end else begin
                total++;
                if (do_re !== '0 || do_im !== '0 || do_idx !== 7'd0) begin
                    bad++;
                    $display("FAIL idle_zero cyc=%0d got re=%h im=%h idx=%0d want all 0",
                             cyc, do_re, do_im, do_idx);
                end
            end
            if (ovf === 1'b1) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int tb_bitrev(input int v, input int nb);
        int r = 0;
        for (int i = 0; i < nb; i++) begin
            if (((v >> i) & 1) == 1) r = r | (1 << (nb - 1 - i));
        end
        return r;
    endfunction

    task automatic clear_capture();
        cap_re.delete();
        cap_im.delete();
        cap_idx.delete();
        cap_cyc.delete();
        ovf_cnt = 0;
        ovf_cyc = -1;
    endtask

    // Drives n samples re=base+k, im=~re; sel is flipped after the first sample.
    task automatic drive_frame(input logic [1:0] s, input int n, input int base,
                               input int gap_at, input int gap_len, input int ov_k,
                               input logic [W-1:0] ov_re, input logic [W-1:0] ov_im,
                               output int last_edge);
        for (int k = 0; k < n; k++) begin
            di_en = 1'b1;
            sel   = (k == 0) ? s : (s ^ 2'b01);
            if (k == ov_k) begin
                di_re = ov_re;
                di_im = ov_im;
            end else begin
                di_re = W'(base + k);
                di_im = ~W'(base + k);
            end
            @(posedge clock);
            #1;
            if (k == gap_at) begin
                di_en = 1'b0;
                repeat (gap_len) @(posedge clock);
                #1;
            end
        end
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        sel   = s;
        last_edge = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (do_en !== 1'b0) begin bad++; $display("FAIL reset_do_en got=%b want=0", do_en); end
        total++; if (do_re !== '0) begin bad++; $display("FAIL reset_do_re got=%h want=0", do_re); end
        total++; if (do_im !== '0) begin bad++; $display("FAIL reset_do_im got=%h want=0", do_im); end
        total++; if (do_idx !== 7'd0) begin bad++; $display("FAIL reset_do_idx got=%0d want=0", do_idx); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (dbg_state !== RD_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=IDLE", dbg_state); end
        reset  = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_sel64();
        int last;
        logic [W-1:0] exp_re;
        clear_capture();
        drive_frame(SEL_N64, 64, 0, -1, 0, -1, '0, '0, last);
        repeat (80) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 64) begin bad++; $display("FAIL sel64_count got=%0d want=64", cap_re.size()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != last + 2) begin bad++; $display("FAIL sel64_latency got=%0d want=%0d", (cap_cyc.size() == 0) ? -1 : cap_cyc[0], last + 2); end
        for (int n = 0; n < 64 && n < cap_re.size(); n++) begin
            exp_re = W'(tb_bitrev(n, 6));
            total++;
            if (cap_re[n] !== exp_re || cap_im[n] !== ~exp_re || cap_idx[n] !== 7'(n) || cap_cyc[n] != cap_cyc[0] + n) begin
                bad++;
                $display("FAIL sel64_data n=%0d got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", n, cap_re[n], cap_im[n], cap_idx[n], exp_re, ~exp_re, n);
            end
        end
        total++; if (ovf_cnt != 0) begin bad++; $display("FAIL sel64_ovf got=%0d want=0", ovf_cnt); end
    endtask

    task automatic test_back_to_back();
        int l16, l128, la, lb;
        logic [W-1:0] exp_re;
        logic [6:0]   exp_idx;
        clear_capture();
        drive_frame(SEL_N16, 16, 'h100, -1, 0, -1, '0, '0, l16);
        drive_frame(SEL_N128, 128, 'h200, -1, 0, -1, '0, '0, l128);
        repeat (140) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 144) begin bad++; $display("FAIL b2b_16_128_count got=%0d want=144", cap_re.size()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != l16 + 2) begin bad++; $display("FAIL b2b_16_latency got=%0d want=%0d", (cap_cyc.size() == 0) ? -1 : cap_cyc[0], l16 + 2); end
        total++; if (cap_cyc.size() < 17 || cap_cyc[16] != l128 + 2) begin bad++; $display("FAIL b2b_128_latency got=%0d want=%0d", (cap_cyc.size() < 17) ? -1 : cap_cyc[16], l128 + 2); end
        for (int n = 0; n < 144 && n < cap_re.size(); n++) begin
            exp_re  = (n < 16) ? W'('h100 + tb_bitrev(n, 4)) : W'('h200 + tb_bitrev(n - 16, 7));
            exp_idx = (n < 16) ? 7'(n) : 7'(n - 16);
            total++;
            if (cap_re[n] !== exp_re || cap_im[n] !== ~exp_re || cap_idx[n] !== exp_idx) begin
                bad++;
                $display("FAIL b2b_16_128_data n=%0d got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", n, cap_re[n], cap_im[n], cap_idx[n], exp_re, ~exp_re, exp_idx);
            end
        end
        total++; if (ovf_cnt != 0) begin bad++; $display("FAIL b2b_16_128_ovf got=%0d want=0", ovf_cnt); end

        clear_capture();
        drive_frame(SEL_N64, 64, 'h300, -1, 0, -1, '0, '0, la);
        drive_frame(SEL_N64, 64, 'h400, -1, 0, -1, '0, '0, lb);
        repeat (80) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 128) begin bad++; $display("FAIL b2b_64_64_count got=%0d want=128", cap_re.size()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != la + 2) begin bad++; $display("FAIL b2b_64_latency got=%0d want=%0d", (cap_cyc.size() == 0) ? -1 : cap_cyc[0], la + 2); end
        for (int n = 0; n < 128 && n < cap_re.size(); n++) begin
            exp_re = (n < 64) ? W'('h300 + tb_bitrev(n, 6)) : W'('h400 + tb_bitrev(n - 64, 6));
            total++;
            if (cap_re[n] !== exp_re || cap_idx[n] !== 7'(n % 64) || cap_cyc[n] != cap_cyc[0] + n) begin
                bad++;
                $display("FAIL b2b_64_64_data n=%0d got re=%h idx=%0d cyc=%0d want re=%h idx=%0d cyc=%0d", n, cap_re[n], cap_idx[n], cap_cyc[n], exp_re, n % 64, cap_cyc[0] + n);
            end
        end
        total++; if (ovf_cnt != 0) begin bad++; $display("FAIL b2b_64_64_ovf got=%0d want=0", ovf_cnt); end
    endtask

    task automatic test_gap();
        int last;
        logic [W-1:0] exp_re;
        clear_capture();
        drive_frame(SEL_N32, 32, 0, 10, 3, -1, '0, '0, last);
        repeat (50) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 32) begin bad++; $display("FAIL gap_count got=%0d want=32", cap_re.size()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != last + 2) begin bad++; $display("FAIL gap_latency got=%0d want=%0d", (cap_cyc.size() == 0) ? -1 : cap_cyc[0], last + 2); end
        total++; if (cap_re.size() < 2 || cap_re[1] !== 16'd16) begin bad++; $display("FAIL gap_re_at_1 got=%h want=0010", (cap_re.size() < 2) ? 16'hxxxx : cap_re[1]); end
        for (int n = 0; n < 32 && n < cap_re.size(); n++) begin
            exp_re = W'(tb_bitrev(n, 5));
            total++;
            if (cap_re[n] !== exp_re || cap_im[n] !== ~exp_re || cap_idx[n] !== 7'(n) || cap_cyc[n] != cap_cyc[0] + n) begin
                bad++;
                $display("FAIL gap_data n=%0d got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", n, cap_re[n], cap_im[n], cap_idx[n], exp_re, ~exp_re, n);
            end
        end
    endtask

    task automatic test_overflow();
        int l128, l16, lr;
        logic [W-1:0] exp_re;
        clear_capture();
        drive_frame(SEL_N128, 128, 'h500, -1, 0, -1, '0, '0, l128);
        drive_frame(SEL_N16, 16, 'h600, -1, 0, -1, '0, '0, l16);
        repeat (150) @(posedge clock);
        #1;
        total++; if (ovf_cnt != 1) begin bad++; $display("FAIL ovf_pulses got=%0d want=1", ovf_cnt); end
        total++; if (ovf_cyc != l16) begin bad++; $display("FAIL ovf_cycle got=%0d want=%0d", ovf_cyc, l16); end
        total++; if (cap_re.size() != 128) begin bad++; $display("FAIL ovf_count got=%0d want=128", cap_re.size()); end
        for (int n = 0; n < 128 && n < cap_re.size(); n++) begin
            exp_re = W'('h500 + tb_bitrev(n, 7));
            total++;
            if (cap_re[n] !== exp_re || cap_im[n] !== ~exp_re || cap_idx[n] !== 7'(n)) begin
                bad++;
                $display("FAIL ovf_data n=%0d got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", n, cap_re[n], cap_im[n], cap_idx[n], exp_re, ~exp_re, n);
            end
        end

        clear_capture();
        drive_frame(SEL_N16, 16, 'h700, -1, 0, -1, '0, '0, lr);
        repeat (30) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 16) begin bad++; $display("FAIL ovf_recover_count got=%0d want=16", cap_re.size()); end
        for (int n = 0; n < 16 && n < cap_re.size(); n++) begin
            exp_re = W'('h700 + tb_bitrev(n, 4));
            total++;
            if (cap_re[n] !== exp_re || cap_idx[n] !== 7'(n)) begin
                bad++;
                $display("FAIL ovf_recover_data n=%0d got re=%h idx=%0d want re=%h idx=%0d", n, cap_re[n], cap_idx[n], exp_re, n);
            end
        end
    endtask

    task automatic test_extreme();
        int last, k;
        logic [W-1:0] exp_re, exp_im;
        clear_capture();
        drive_frame(SEL_N64, 64, 0, -1, 0, 1, 16'h7FFF, 16'h8000, last);
        repeat (80) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 64) begin bad++; $display("FAIL extreme_count got=%0d want=64", cap_re.size()); end
        total++;
        if (cap_re.size() < 33 || cap_re[32] !== 16'h7FFF || cap_im[32] !== 16'h8000 || cap_idx[32] !== 7'd32) begin
            bad++;
            $display("FAIL extreme_idx32 got re=%h im=%h want re=7fff im=8000 idx=32", (cap_re.size() < 33) ? 16'hxxxx : cap_re[32], (cap_im.size() < 33) ? 16'hxxxx : cap_im[32]);
        end
        for (int n = 0; n < 64 && n < cap_re.size(); n++) begin
            k = tb_bitrev(n, 6);
            exp_re = (k == 1) ? 16'h7FFF : W'(k);
            exp_im = (k == 1) ? 16'h8000 : ~W'(k);
            total++;
            if (cap_re[n] !== exp_re || cap_im[n] !== exp_im || cap_idx[n] !== 7'(n)) begin
                bad++;
                $display("FAIL extreme_data n=%0d got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", n, cap_re[n], cap_im[n], cap_idx[n], exp_re, exp_im, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int last, dummy;
        bit hit;
        logic [W-1:0] exp_re;
        clear_capture();
        drive_frame(SEL_N64, 64, 'h800, -1, 0, -1, '0, '0, last);
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(posedge clock);
            #1;
            if (do_en === 1'b1 && do_idx === 7'd19) hit = 1'b1;
        end
        total++; if (!hit) begin bad++; $display("FAIL rstmid_reach_20 got=timeout want=idx19 within 200 cycles"); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++; if (do_en !== 1'b0) begin bad++; $display("FAIL rstmid_do_en got=%b want=0", do_en); end
        total++; if (dbg_state !== RD_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d want=IDLE", dbg_state); end
        reset = 1'b0;
        repeat (80) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 20) begin bad++; $display("FAIL rstmid_no_more got=%0d want=20", cap_re.size()); end

        // Partial frame then reset: the partial samples must not shift the next frame.
        clear_capture();
        drive_frame(SEL_N64, 5, 'hA00, -1, 0, -1, '0, '0, dummy);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_frame(SEL_N16, 16, 'h900, -1, 0, -1, '0, '0, last);
        repeat (30) @(posedge clock);
        #1;
        total++; if (cap_re.size() != 16) begin bad++; $display("FAIL rstmid_new_count got=%0d want=16", cap_re.size()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != last + 2) begin bad++; $display("FAIL rstmid_new_latency got=%0d want=%0d", (cap_cyc.size() == 0) ? -1 : cap_cyc[0], last + 2); end
        for (int n = 0; n < 16 && n < cap_re.size(); n++) begin
            exp_re = W'('h900 + tb_bitrev(n, 4));
            total++;
            if (cap_re[n] !== exp_re || cap_idx[n] !== 7'(n)) begin
                bad++;
                $display("FAIL rstmid_new_data n=%0d got re=%h idx=%0d want re=%h idx=%0d", n, cap_re[n], cap_idx[n], exp_re, n);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_sel64();
        test_back_to_back();
        test_gap();
        test_overflow();
        test_extreme();
        test_reset_mid();
        repeat (4) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
